regfile_scoreboard: RTL and testbench

- Parametrised register file with a busy-bit scoreboard, for the pipelined and multi-cycle successors of the single-cycle core.
- Provides NRD combinational read ports, one writeback port, same-cycle write-to-read bypass and a hardwired-zero r0.
- Tracks registers with an outstanding producer and raises per-port stall flags until writeback.
- Sits between decode (reads and issue) and writeback in the processor top.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/rf_scoreboard.sv | 35 +++
 rtl/regfile_scoreboard.sv | 87 ++++++++
 tb/tb_regfile_scoreboard.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register file / scoreboard slice.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set at issue, cleared at writeback.
// A same-edge issue beats the clear so a newer producer is never lost.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_we,
  input  logic [AW-1:0]    issue_addr,
  input  logic             wb_we,
  input  logic [AW-1:0]    wb_addr,
  output logic [NREGS-1:0] busy_vec
);

  // r0 has no flop at all, so it can never read as busy
  logic [NREGS-1:1] busy_reg;

  for (genvar gi = 1; gi < NREGS; gi++) begin : g_busy
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        busy_reg[gi] <= 1'b0;
      end else if (issue_we && issue_addr == AW'(gi)) begin
        busy_reg[gi] <= 1'b1;
      end else if (wb_we && wb_addr == AW'(gi)) begin
        busy_reg[gi] <= 1'b0;
      end
    end
  end

  assign busy_vec = {busy_reg, 1'b0};

endmodule

// File: rtl/regfile_scoreboard.sv
// NRD-read / 1-write register file with writeback bypass, hardwired r0 and busy scoreboard.
// Optional: define REGFILE_STALL_CNT_EN to add stall_cnt_o, a saturating stall-cycle counter.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic [0:0]          clk,
  input  logic                rst,
  input  logic [NRD-1:0]      rd_en_i,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  output logic                stall_o,
  input  logic                issue_we_i,
  input  logic [AW-1:0]       issue_addr_i,
  input  logic                wb_we_i,
  input  logic [AW-1:0]       wb_addr_i,
  input  logic [XLEN-1:0]     wb_data_i,
  output logic [NREGS-1:0]    busy_vec_o
`ifdef REGFILE_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt_o
`endif
);

  logic [XLEN-1:0]  regs_reg [NREGS];
  logic [NREGS-1:0] busy_vec;

  // r0 is cleared at reset and never written, so indexing it always yields 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NREGS; k++) begin
        regs_reg[k] <= '0;
      end
    end else if (wb_we_i && wb_addr_i != AW'(ZERO_REG)) begin
      regs_reg[wb_addr_i] <= wb_data_i;
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue_we   (issue_we_i),
    .issue_addr (issue_addr_i),
    .wb_we      (wb_we_i),
    .wb_addr    (wb_addr_i),
    .busy_vec   (busy_vec)
  );

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] addr;
    logic          wb_hit;

    assign addr   = rd_addr_i[gi*AW +: AW];
    assign wb_hit = wb_we_i && (wb_addr_i == addr);
    // A matching writeback both forwards its data and releases the stall
    assign rd_data_o[gi*XLEN +: XLEN] = (wb_hit && addr != AW'(ZERO_REG)) ? wb_data_i
                                                                          : regs_reg[addr];
    assign rd_busy_o[gi] = rd_en_i[gi] && busy_vec[addr] && !wb_hit;
  end

  assign stall_o    = |rd_busy_o;
  assign busy_vec_o = busy_vec;

`ifdef REGFILE_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= '0;
    end else if (stall_o && stall_cnt_reg != 32'hFFFF_FFFF) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
`else
  // stall counter not built in this configuration
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus randomized traffic vs a reference model.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NRD-1:0]      rd_en;
  logic [AW-1:0]       ra [NRD];
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                stall;
  logic                issue_we;
  logic [AW-1:0]       issue_addr;
  logic                wb_we;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic [NREGS-1:0]    busy_vec;
`ifdef REGFILE_STALL_CNT_EN
  logic [31:0]         stall_cnt;
`endif

  always #5 clk = ~clk;

  always_comb begin
    rd_addr = '0;
    for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = ra[i];
  end

  regfile_scoreboard #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRD   (NRD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_en_i      (rd_en),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .rd_busy_o    (rd_busy),
    .stall_o      (stall),
    .issue_we_i   (issue_we),
    .issue_addr_i (issue_addr),
    .wb_we_i      (wb_we),
    .wb_addr_i    (wb_addr),
    .wb_data_i    (wb_data),
    .busy_vec_o   (busy_vec)
`ifdef REGFILE_STALL_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt)
`endif
  );

  // Reference model: architectural register values, outstanding-producer flags, stall count
  logic [XLEN-1:0] mregs [NREGS];
  bit              mbusy [NREGS];
  logic [31:0]     mcnt;
  int              errors = 0;
  int              checks = 0;

  function automatic logic [XLEN-1:0] exp_data(int p);
    int a = int'(ra[p]);
    if (a == 0) return '0;
    if (wb_we && int'(wb_addr) == a) return wb_data;
    return mregs[a];
  endfunction

  function automatic bit exp_busy(int p);
    int a = int'(ra[p]);
    return rd_en[p] && mbusy[a] && !(wb_we && int'(wb_addr) == a);
  endfunction

  function automatic bit exp_stall();
    for (int p = 0; p < NRD; p++) if (exp_busy(p)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NREGS-1:0] exp_vec();
    logic [NREGS-1:0] v = '0;
    for (int a = 0; a < NREGS; a++) v[a] = mbusy[a];
    return v;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < NREGS; a++) begin
      mregs[a] = '0;
      mbusy[a] = 1'b0;
    end
    mcnt = '0;
  endtask

  task automatic idle();
    rd_en = '0; issue_we = 1'b0; issue_addr = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    for (int p = 0; p < NRD; p++) ra[p] = '0;
  endtask

  // Advance one edge: the model applies this cycle's inputs, then inputs may change at +1
  task automatic tick();
    @(posedge clk);
    if (exp_stall() && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 32'd1;
    if (wb_we && wb_addr != 0) mregs[wb_addr] = wb_data;
    if (wb_we) mbusy[wb_addr] = 1'b0;
    if (issue_we && issue_addr != 0) mbusy[issue_addr] = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (busy_vec !== '0) begin errors++; $display("FAIL reset_busy_vec: got %h expected 0", busy_vec); end
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int a = 0; a < NREGS; a++) begin
      ra[0] = AW'(a);
      ra[1] = AW'(NREGS - 1 - a);
      rd_en = '1;
      #4;
      for (int p = 0; p < NRD; p++) begin
        checks++;
        if (rd_data[p*XLEN +: XLEN] !== '0) begin
          errors++;
          $display("FAIL reset_read port%0d r%0d: got %h expected 0", p, ra[p], rd_data[p*XLEN +: XLEN]);
        end
      end
      checks++;
      if (rd_busy !== '0 || busy_vec !== '0) begin
        errors++;
        $display("FAIL reset_busy r%0d: got rd_busy=%b busy_vec=%h expected 0/0", a, rd_busy, busy_vec);
      end
      tick();
    end
    $display("test_reset done: errors=%0d", errors);
  endtask

  task automatic test_bypass();
    idle();
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF; ra[0] = 5'd5;
    #4;
    checks++;
    if (rd_data[0 +: XLEN] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL bypass_same_cycle: got %h expected deadbeef", rd_data[0 +: XLEN]);
    end
    tick();
    wb_we = 1'b0; wb_data = '0;
    #4;
    checks++;
    if (rd_data[0 +: XLEN] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL bypass_stored: got %h expected deadbeef", rd_data[0 +: XLEN]);
    end
    tick();
    $display("test_bypass done: errors=%0d", errors);
  endtask

  task automatic test_stall_release();
    idle();
    issue_we = 1'b1; issue_addr = 5'd7;
    #4;
    checks++;
    if (busy_vec[7] !== 1'b0) begin errors++; $display("FAIL issue_latency: got busy=%b expected 0", busy_vec[7]); end
    tick();
    issue_we = 1'b0; rd_en = 2'b01; ra[0] = 5'd7;
    for (int c = 0; c < 3; c++) begin
      #4;
      checks++;
      if (rd_busy !== 2'b01 || stall !== 1'b1) begin
        errors++; $display("FAIL stall_hold c%0d: got rd_busy=%b stall=%b expected 01/1", c, rd_busy, stall);
      end
      tick();
    end
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h12;
    #4;
    checks++;
    if (stall !== 1'b0 || rd_data[0 +: XLEN] !== 32'h12) begin
      errors++; $display("FAIL stall_release: got stall=%b data=%h expected 0/00000012", stall, rd_data[0 +: XLEN]);
    end
    tick();
    idle();
`ifdef REGFILE_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd3) begin errors++; $display("FAIL stall_cnt_three: got %0d expected 3", stall_cnt); end
`endif
    $display("test_stall_release done: errors=%0d", errors);
  endtask

  task automatic test_set_wins();
    idle();
    issue_we = 1'b1; issue_addr = 5'd9; wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
    tick();
    idle();
    ra[1] = 5'd9;
    #1;
    checks++;
    if (busy_vec[9] !== 1'b1) begin errors++; $display("FAIL set_wins_busy: got %b expected 1", busy_vec[9]); end
    checks++;
    if (rd_data[XLEN +: XLEN] !== 32'h55) begin
      errors++; $display("FAIL set_wins_data: got %h expected 00000055", rd_data[XLEN +: XLEN]);
    end
    tick();
    $display("test_set_wins done: errors=%0d", errors);
  endtask

  task automatic test_r0();
    idle();
    issue_we = 1'b1; issue_addr = 5'd0; wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF;
    #4;
    checks++;
    if (rd_data[0 +: XLEN] !== '0) begin errors++; $display("FAIL r0_no_bypass: got %h expected 0", rd_data[0 +: XLEN]); end
    tick();
    idle();
    rd_en = 2'b11;
    #1;
    checks++;
    if (busy_vec[0] !== 1'b0 || rd_busy !== 2'b00) begin
      errors++; $display("FAIL r0_busy: got busy0=%b rd_busy=%b expected 0/00", busy_vec[0], rd_busy);
    end
    checks++;
    if (rd_data !== '0) begin errors++; $display("FAIL r0_read: got %h expected 0", rd_data); end
    tick();
    $display("test_r0 done: errors=%0d", errors);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rd_en = NRD'($urandom);
      for (int p = 0; p < NRD; p++) ra[p] = rand_addr();
      issue_we = ($urandom_range(0, 2) == 0);
      issue_addr = rand_addr();
      wb_we = ($urandom_range(0, 1) == 0);
      wb_addr = rand_addr();
      wb_data = $urandom;
      #4;
      for (int p = 0; p < NRD; p++) begin
        checks++;
        if (rd_data[p*XLEN +: XLEN] !== exp_data(p)) begin
          errors++;
          $display("FAIL rand_data n%0d port%0d r%0d: got %h expected %h", n, p, ra[p], rd_data[p*XLEN +: XLEN], exp_data(p));
        end
        checks++;
        if (rd_busy[p] !== exp_busy(p)) begin
          errors++; $display("FAIL rand_busy n%0d port%0d: got %b expected %b", n, p, rd_busy[p], exp_busy(p));
        end
      end
      checks++;
      if (stall !== exp_stall()) begin errors++; $display("FAIL rand_stall n%0d: got %b expected %b", n, stall, exp_stall()); end
      checks++;
      if (busy_vec !== exp_vec()) begin errors++; $display("FAIL rand_busy_vec n%0d: got %h expected %h", n, busy_vec, exp_vec()); end
      tick();
    end
    idle();
`ifdef REGFILE_STALL_CNT_EN
    checks++;
    if (stall_cnt !== mcnt) begin errors++; $display("FAIL rand_stall_cnt: got %0d expected %0d", stall_cnt, mcnt); end
`endif
    $display("test_random done: errors=%0d", errors);
  endtask

  task automatic test_reset_midop();
    idle();
    issue_we = 1'b1; issue_addr = 5'd3;
    tick();
    idle();
    rd_en = 2'b01; ra[0] = 5'd3;
    #1;
    checks++;
    if (busy_vec !== exp_vec() || busy_vec[3] !== 1'b1) begin
      errors++; $display("FAIL midop_pre: got %h expected %h", busy_vec, exp_vec());
    end
    #1 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (busy_vec !== '0 || stall !== 1'b0) begin
      errors++; $display("FAIL midop_reset: got busy_vec=%h stall=%b expected 0/0", busy_vec, stall);
    end
    checks++;
    if (rd_data !== '0) begin errors++; $display("FAIL midop_regs: got %h expected 0", rd_data); end
`ifdef REGFILE_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL midop_stall_cnt: got %0d expected 0", stall_cnt); end
`endif
    @(posedge clk); #1;
    rst = 1'b1;
    $display("test_reset_midop done: errors=%0d", errors);
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_stall_release();
    test_set_wins();
    test_r0();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
